// File: rtl/alu_result_latch_if.sv
// Bundle between the ALU result latch and its neighbours: ALU-side beat input,
// MEM/WB-side head output and the EX forwarding tap. clk/rst are kept out of here.
// Optional parity pins exist only when ALU_RESULT_PARITY_EN is defined.
interface alu_result_latch_if #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      in_result;
  logic [REG_ADDR_W-1:0] in_rd;
  logic                  in_reg_write;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_result;
  logic [REG_ADDR_W-1:0] out_rd;
  logic                  out_reg_write;
  logic                  fwd_valid;
  logic [REG_ADDR_W-1:0] fwd_rd;
  logic [WIDTH-1:0]      fwd_data;
`ifdef ALU_RESULT_PARITY_EN
  logic                  in_parity;
  logic                  out_parity;
  logic                  parity_err;

  // Environment side: ALU producer, MEM/WB consumer, pipeline control.
  modport master (
    output flush, in_valid, in_result, in_rd, in_reg_write, in_parity, out_ready,
    input  in_ready, out_valid, out_result, out_rd, out_reg_write, out_parity,
    input  parity_err, fwd_valid, fwd_rd, fwd_data
  );

  // Latch side.
  modport slave (
    input  flush, in_valid, in_result, in_rd, in_reg_write, in_parity, out_ready,
    output in_ready, out_valid, out_result, out_rd, out_reg_write, out_parity,
    output parity_err, fwd_valid, fwd_rd, fwd_data
  );
`else
  // Environment side: ALU producer, MEM/WB consumer, pipeline control.
  modport master (
    output flush, in_valid, in_result, in_rd, in_reg_write, out_ready,
    input  in_ready, out_valid, out_result, out_rd, out_reg_write,
    input  fwd_valid, fwd_rd, fwd_data
  );

  // Latch side.
  modport slave (
    input  flush, in_valid, in_result, in_rd, in_reg_write, out_ready,
    output in_ready, out_valid, out_result, out_rd, out_reg_write,
    output fwd_valid, fwd_rd, fwd_data
  );
`endif
endinterface

// File: rtl/alu_result_latch.sv
// ALU result pipeline latch: 2-entry skid buffer (head H, skid S) feeding MEM/WB, plus EX forwarding tap from H.
// Latency: 1 cycle from accept to out_* when empty or when draining with one entry; all outputs are registers.
// Backpressure: in_ready is registered and drops only when both entries are full; optional parity via ALU_RESULT_PARITY_EN.
module alu_result_latch #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5
) (
  input logic               clk,
  input logic               rst,
  alu_result_latch_if.slave lat
);

  // One buffered beat; parity bit rides along only when the feature is built in.
  typedef struct packed {
`ifdef ALU_RESULT_PARITY_EN
    logic                  par;
`endif
    logic                  rw;
    logic [REG_ADDR_W-1:0] rd;
    logic [WIDTH-1:0]      res;
  } beat_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   in_ready_q;
  logic   h_vld_q, h_vld_d;
  beat_t  h_q, h_d;
  beat_t  s_q, s_d;
  beat_t  in_beat;
  logic   fwd_vld_q, fwd_vld_d;
  logic   accept;
  logic   drain;
`ifdef ALU_RESULT_PARITY_EN
  logic   perr_q, perr_d;
`endif

  assign accept = lat.in_valid & in_ready_q;
  assign drain  = h_vld_q & lat.out_ready;

  // Pack the incoming ALU beat.
  always_comb begin
    in_beat     = '0;
    in_beat.rw  = lat.in_reg_write;
    in_beat.rd  = lat.in_rd;
    in_beat.res = lat.in_result;
`ifdef ALU_RESULT_PARITY_EN
    in_beat.par = lat.in_parity;
`endif
  end

  // Next-state and entry movement; flush overrides everything and freezes the data registers
  // so a beat offered during flush can never reach out_result.
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    s_d     = s_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = ONE;
          h_d     = in_beat;
        end
      end
      ONE: begin
        if (accept && drain) begin
          h_d = in_beat;
        end else if (accept) begin
          state_d = FULL;
          s_d     = in_beat;
        end else if (drain) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (drain) begin
          state_d = ONE;
          h_d     = s_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (lat.flush) begin
      state_d = EMPTY;
      h_d     = h_q;
      s_d     = s_q;
    end
  end

  // Head valid and forwarding qualifier are precomputed so both leave the block as flops.
  always_comb begin
    h_vld_d   = (state_d != EMPTY);
    fwd_vld_d = h_vld_d & h_d.rw & (h_d.rd != '0);
  end

`ifdef ALU_RESULT_PARITY_EN
  // Sticky even-parity error on any accepted beat (including one dropped by flush); only rst clears it.
  always_comb begin
    perr_d = perr_q | (accept & (^{lat.in_result, lat.in_parity}));
  end
`endif

  // State, storage and registered outputs; rst wins over flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b0;
      h_vld_q    <= 1'b0;
      h_q        <= '0;
      s_q        <= '0;
      fwd_vld_q  <= 1'b0;
`ifdef ALU_RESULT_PARITY_EN
      perr_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != FULL);
      h_vld_q    <= h_vld_d;
      h_q        <= h_d;
      s_q        <= s_d;
      fwd_vld_q  <= fwd_vld_d;
`ifdef ALU_RESULT_PARITY_EN
      perr_q     <= perr_d;
`endif
    end
  end

  assign lat.in_ready      = in_ready_q;
  assign lat.out_valid     = h_vld_q;
  assign lat.out_result    = h_q.res;
  assign lat.out_rd        = h_q.rd;
  assign lat.out_reg_write = h_q.rw;
  assign lat.fwd_valid     = fwd_vld_q;
  assign lat.fwd_rd        = h_q.rd;
  assign lat.fwd_data      = h_q.res;
`ifdef ALU_RESULT_PARITY_EN
  assign lat.out_parity    = h_q.par;
  assign lat.parity_err    = perr_q;
`endif

  // Head must not change while it is offered and not taken (unless flushed).
  a_head_stable: assert property (@(posedge clk) disable iff (rst)
    (h_vld_q && !lat.out_ready && !lat.flush) |=> (h_vld_q && $stable(h_q)));

  // in_ready low means both entries are occupied.
  a_ready_full: assert property (@(posedge clk) disable iff (rst)
    (!in_ready_q && state_q != EMPTY) |-> (state_q == FULL));

endmodule

// File: tb/tb_alu_result_latch.sv
// Testbench for alu_result_latch: directed beats, expected beats queued at accept time,
// independent monitor pops and compares on every out_valid & out_ready.
module tb_alu_result_latch;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        rw;
    logic        par;
  } exp_t;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  exp_t sb[$];
  exp_t mon_e;

  alu_result_latch_if #(.WIDTH(32), .REG_ADDR_W(5)) lat ();

  alu_result_latch #(.WIDTH(32), .REG_ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .lat (lat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one beat; it counts as accepted on the first edge where in_ready was high.
  task automatic send(input logic [31:0] d, input logic [4:0] rd, input logic rw, input logic par);
    bit   ok;
    exp_t e;
    lat.in_valid     = 1'b1;
    lat.in_result    = d;
    lat.in_rd        = rd;
    lat.in_reg_write = rw;
`ifdef ALU_RESULT_PARITY_EN
    lat.in_parity    = par;
`endif
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      ok = lat.in_ready;
      @(posedge clk);
      #1;
    end
    lat.in_valid = 1'b0;
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 20 cycles");
    end else begin
      e.res = d;
      e.rd  = rd;
      e.rw  = rw;
      e.par = par;
      sb.push_back(e);
    end
  endtask

  // Flush for one cycle while offering a beat that must be dropped.
  task automatic do_flush();
    lat.flush        = 1'b1;
    lat.in_valid     = 1'b1;
    lat.in_result    = 32'hDDDDDDDD;
    lat.in_rd        = 5'd9;
    lat.in_reg_write = 1'b1;
`ifdef ALU_RESULT_PARITY_EN
    lat.in_parity    = ^32'hDDDDDDDD;
`endif
    @(posedge clk);
    #1;
    lat.flush    = 1'b0;
    lat.in_valid = 1'b0;
    sb.delete();
  endtask

  // Monitor: every handshake on the output side must match the oldest expected beat.
  always @(negedge clk) begin
    if (!rst && lat.out_valid && lat.out_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_beat: got result %h rd %0d, expected no beat", lat.out_result, lat.out_rd);
      end else begin
        mon_e = sb.pop_front();
        check("out_result", lat.out_result, mon_e.res);
        check("out_rd", lat.out_rd, mon_e.rd);
        check("out_reg_write", lat.out_reg_write, mon_e.rw);
        check("fwd_valid", lat.fwd_valid, mon_e.rw && (mon_e.rd != 5'd0));
        check("fwd_rd", lat.fwd_rd, mon_e.rd);
        check("fwd_data", lat.fwd_data, mon_e.res);
`ifdef ALU_RESULT_PARITY_EN
        check("out_parity", lat.out_parity, mon_e.par);
`endif
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tests            = 0;
    fails            = 0;
    rst              = 1'b1;
    lat.flush        = 1'b0;
    lat.in_valid     = 1'b0;
    lat.in_result    = '0;
    lat.in_rd        = '0;
    lat.in_reg_write = 1'b0;
    lat.out_ready    = 1'b0;
`ifdef ALU_RESULT_PARITY_EN
    lat.in_parity    = 1'b0;
`endif

    // 1: reset state, in_ready rises one cycle after release
    idle(2);
    check("rst_out_valid", lat.out_valid, 0);
    check("rst_in_ready", lat.in_ready, 0);
    check("rst_out_result", lat.out_result, 0);
    check("rst_out_rd", lat.out_rd, 0);
    check("rst_fwd_valid", lat.fwd_valid, 0);
    check("rst_fwd_data", lat.fwd_data, 0);
    rst = 1'b0;
    check("release_in_ready_lo", lat.in_ready, 0);
    idle(1);
    check("release_in_ready_hi", lat.in_ready, 1);

    // 2: single beat, one-cycle latency, forwarding
    lat.out_ready = 1'b1;
    send(32'hAAAAAAAA, 5'd5, 1'b1, ^32'hAAAAAAAA);
    check("t2_out_valid", lat.out_valid, 1);
    check("t2_out_result", lat.out_result, 32'hAAAAAAAA);
    check("t2_fwd_valid", lat.fwd_valid, 1);
    check("t2_fwd_rd", lat.fwd_rd, 5);
    idle(2);

    // 3: fill both entries under backpressure, then drain in order
    lat.out_ready = 1'b0;
    send(32'h55555555, 5'd1, 1'b1, ^32'h55555555);
    send(32'hFFFFFFFF, 5'd2, 1'b1, ^32'hFFFFFFFF);
    check("t3_in_ready_full", lat.in_ready, 0);
    check("t3_head_first", lat.out_result, 32'h55555555);
    idle(2);
    check("t3_head_stable", lat.out_result, 32'h55555555);
    check("t3_valid_stable", lat.out_valid, 1);
    lat.out_ready = 1'b1;
    idle(1);
    check("t3_head_second", lat.out_result, 32'hFFFFFFFF);
    check("t3_in_ready_back", lat.in_ready, 1);
    idle(1);
    check("t3_empty", lat.out_valid, 0);

    // 4: r0 never forwarded; non-writing beat never forwarded
    send(32'hA5A5A5A5, 5'd0, 1'b1, ^32'hA5A5A5A5);
    check("t4_r0_valid", lat.out_valid, 1);
    check("t4_r0_fwd", lat.fwd_valid, 0);
    send(32'h12345678, 5'd3, 1'b0, ^32'h12345678);
    check("t4_rw0_rd", lat.out_rd, 3);
    check("t4_rw0_fwd", lat.fwd_valid, 0);
    idle(2);

    // 5a: flush while FULL
    lat.out_ready = 1'b0;
    send(32'h11111111, 5'd4, 1'b1, ^32'h11111111);
    send(32'h22222222, 5'd6, 1'b1, ^32'h22222222);
    do_flush();
    check("t5_full_valid", lat.out_valid, 0);
    check("t5_full_in_ready", lat.in_ready, 1);
    check("t5_full_no_ddd", lat.out_result == 32'hDDDDDDDD, 0);
    check("t5_full_fwd", lat.fwd_valid, 0);
    lat.out_ready = 1'b1;
    idle(3);

    // 5b: flush while ONE with a beat that would otherwise be accepted
    lat.out_ready = 1'b0;
    send(32'h33333333, 5'd10, 1'b1, ^32'h33333333);
    do_flush();
    check("t5_one_valid", lat.out_valid, 0);
    check("t5_one_in_ready", lat.in_ready, 1);
    check("t5_one_no_ddd", lat.out_result == 32'hDDDDDDDD, 0);
    idle(2);
    check("t5_one_stays_empty", lat.out_valid, 0);
    lat.out_ready = 1'b1;
    send(32'h0BADF00D, 5'd7, 1'b1, ^32'h0BADF00D);
    check("t5_resume", lat.out_result, 32'h0BADF00D);
    idle(2);

`ifdef ALU_RESULT_PARITY_EN
    // 6: sticky parity error, survives flush, cleared by rst
    check("t6_perr_init", lat.parity_err, 0);
    send(32'h00000001, 5'd8, 1'b1, 1'b0);
    check("t6_perr_set", lat.parity_err, 1);
    idle(2);
    do_flush();
    check("t6_perr_flush", lat.parity_err, 1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("t6_perr_rst", lat.parity_err, 0);
    idle(1);
    send(32'h00000001, 5'd8, 1'b1, 1'b1);
    check("t6_perr_good", lat.parity_err, 0);
    idle(2);
`endif

    idle(3);
    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
